calc_sequencer: RTL and testbench

Control FSM for the keypad calculator datapath. Consumes one-cycle key events, builds operand A and operand B by shifting key bytes into a 32-bit register 8 bits at a time, latches the operator, and hands the operands to the ALU over a req/done handshake. Every operand or result change is pushed to the display through a one-cycle write strobe at a fixed I/O address. It sits between the keypad scanner and the ALU and display port, and replaces the free-running operand register with an explicitly sequenced one.

---
 rtl/calc_pkg.sv | 47 ++++
 rtl/calc_sequencer_key_decoder.sv | 34 +++
 rtl/calc_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_calc_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the keypad calculator sequencer: key codes, operator
// encoding, FSM state codes with their phase mapping, and the display address.
package calc_pkg;

    // ASCII key codes recognised by the sequencer
    localparam logic [7:0] KEY_DIGIT_LO = 8'h30;
    localparam logic [7:0] KEY_DIGIT_HI = 8'h39;
    localparam logic [7:0] KEY_PLUS     = 8'h2B;
    localparam logic [7:0] KEY_MINUS    = 8'h2D;
    localparam logic [7:0] KEY_STAR     = 8'h2A;
    localparam logic [7:0] KEY_EQ       = 8'h3D;
    localparam logic [7:0] KEY_CLR      = 8'h43;

    // ALU operator encoding
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    // FSM state codes
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_OPA  = 3'd1;
    localparam logic [2:0] S_OPB  = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_SHOW = 3'd4;

    // Externally visible phase codes
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_OPA  = 2'd1;
    localparam logic [1:0] PH_OPB  = 2'd2;
    localparam logic [1:0] PH_EXEC = 2'd3;

    localparam logic [31:0] CALC_DISP_ADDR = 32'h0040_0004;

    // IDLE and SHOW both present as "idle/result" to the outside world
    function automatic logic [1:0] state_phase(input logic [2:0] s);
        logic [1:0] ph;
        ph = PH_IDLE;
        case (s)
            S_OPA:   ph = PH_OPA;
            S_OPB:   ph = PH_OPB;
            S_EXEC:  ph = PH_EXEC;
            default: ph = PH_IDLE;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/calc_sequencer_key_decoder.sv
// Combinational classifier: turns a raw key code into digit / operator /
// equals / clear flags plus the operator encoding. Unknown codes raise nothing.
module key_decoder
    import calc_pkg::*;
#(
    parameter int KEY_W = 8
) (
    input  logic [KEY_W-1:0] key_code,
    output logic             is_digit,
    output logic             is_op,
    output logic [1:0]       op,
    output logic             is_eq,
    output logic             is_clr
);

    // Classify the key code
    always_comb begin
        is_digit = (key_code >= KEY_W'(KEY_DIGIT_LO)) && (key_code <= KEY_W'(KEY_DIGIT_HI));
        is_eq    = (key_code == KEY_W'(KEY_EQ));
        is_clr   = (key_code == KEY_W'(KEY_CLR));
        is_op    = 1'b1;
        op       = OP_ADD;
        if (key_code == KEY_W'(KEY_PLUS)) begin
            op = OP_ADD;
        end else if (key_code == KEY_W'(KEY_MINUS)) begin
            op = OP_SUB;
        end else if (key_code == KEY_W'(KEY_STAR)) begin
            op = OP_MUL;
        end else begin
            is_op = 1'b0;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Keypad calculator control FSM. Builds operand A and B from digit keys
// (8 bits per key, most recent key in the low byte), latches the operator,
// runs one ALU transaction per '=' and strobes every operand/result change
// to the memory-mapped display.
//
// Handshake: alu_req is high for the whole EXEC state; alu_a/alu_b/alu_op are
// flop outputs that cannot change while alu_req=1. alu_done is a one-cycle
// pulse only looked at while alu_req=1; the edge that sees it leaves EXEC,
// so alu_req drops and the result strobe appears in the same following cycle.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int               KEY_W     = 8,
    parameter int               DATA_W    = 32,
    parameter int               MAX_KEYS  = 4,
    parameter logic [DATA_W-1:0] DISP_ADDR = DATA_W'(CALC_DISP_ADDR)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_valid,
    input  logic [KEY_W-1:0]  key_code,
    output logic              alu_req,
    output logic [1:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    output logic              disp_we,
    output logic [DATA_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic [1:0]        phase,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_KEYS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_KEYS);

    logic             is_digit;
    logic             is_op;
    logic [1:0]       key_op;
    logic             is_eq;
    logic             is_clr;

    logic [2:0]        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              disp_we_q, disp_we_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d;

    key_decoder #(.KEY_W(KEY_W)) u_key_decoder (
        .key_code (key_code),
        .is_digit (is_digit),
        .is_op    (is_op),
        .op       (key_op),
        .is_eq    (is_eq),
        .is_clr   (is_clr)
    );

    // Next-state, operand and display-strobe logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_a_d     = cnt_a_q;
        cnt_b_d     = cnt_b_q;
        op_d        = op_q;
        res_d       = res_q;
        disp_we_d   = 1'b0;
        disp_data_d = disp_data_q;

        if (state_q == S_EXEC) begin
            // Keys are dropped here, including one coinciding with alu_done
            if (alu_done) begin
                res_d       = alu_result;
                state_d     = S_SHOW;
                disp_we_d   = 1'b1;
                disp_data_d = alu_result;
            end
        end else if (key_valid) begin
            if (is_clr) begin
                state_d     = S_IDLE;
                a_d         = '0;
                b_d         = '0;
                cnt_a_d     = '0;
                cnt_b_d     = '0;
                op_d        = OP_ADD;
                disp_we_d   = 1'b1;
                disp_data_d = '0;
            end else begin
                case (state_q)
                    S_IDLE, S_SHOW: begin
                        if (is_digit) begin
                            // Fresh calculation; any previous result is discarded
                            a_d         = DATA_W'(key_code);
                            cnt_a_d     = CNT_W'(1);
                            b_d         = '0;
                            cnt_b_d     = '0;
                            state_d     = S_OPA;
                            disp_we_d   = 1'b1;
                            disp_data_d = DATA_W'(key_code);
                        end else if (is_op && (state_q == S_SHOW)) begin
                            // Chain: the last result becomes a full operand A
                            a_d     = res_q;
                            cnt_a_d = CNT_MAX;
                            b_d     = '0;
                            cnt_b_d = '0;
                            op_d    = key_op;
                            state_d = S_OPB;
                        end
                    end
                    S_OPA: begin
                        if (is_digit && (cnt_a_q < CNT_MAX)) begin
                            a_d         = (a_q << KEY_W) | DATA_W'(key_code);
                            cnt_a_d     = cnt_a_q + CNT_W'(1);
                            disp_we_d   = 1'b1;
                            disp_data_d = (a_q << KEY_W) | DATA_W'(key_code);
                        end else if (is_op && (cnt_a_q != '0)) begin
                            op_d    = key_op;
                            b_d     = '0;
                            cnt_b_d = '0;
                            state_d = S_OPB;
                        end
                    end
                    S_OPB: begin
                        if (is_digit && (cnt_b_q < CNT_MAX)) begin
                            b_d         = (b_q << KEY_W) | DATA_W'(key_code);
                            cnt_b_d     = cnt_b_q + CNT_W'(1);
                            disp_we_d   = 1'b1;
                            disp_data_d = (b_q << KEY_W) | DATA_W'(key_code);
                        end else if (is_op && (cnt_b_q == '0)) begin
                            // Operator may still be changed until B is started
                            op_d = key_op;
                        end else if (is_eq && (cnt_b_q != '0)) begin
                            state_d = S_EXEC;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_a_q     <= '0;
            cnt_b_q     <= '0;
            op_q        <= OP_ADD;
            res_q       <= '0;
            disp_we_q   <= 1'b0;
            disp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_a_q     <= cnt_a_d;
            cnt_b_q     <= cnt_b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            disp_we_q   <= disp_we_d;
            disp_data_q <= disp_data_d;
        end
    end

    // Outputs come straight from flops so they fall with reset immediately
    always_comb begin
        alu_req   = (state_q == S_EXEC);
        busy      = (state_q == S_EXEC);
        alu_op    = op_q;
        alu_a     = a_q;
        alu_b     = b_q;
        disp_we   = disp_we_q;
        disp_data = disp_data_q;
        disp_addr = DISP_ADDR;
        phase     = state_phase(state_q);
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer. Display writes are checked
// through an expected queue; FSM outputs are checked at chosen points.
module tb_calc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        alu_req;
    logic [1:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_done;
    logic [31:0] alu_result;
    logic        disp_we;
    logic [31:0] disp_addr;
    logic [31:0] disp_data;
    logic [1:0]  phase;
    logic        busy;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    calc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_req    (alu_req),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .disp_we    (disp_we),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .phase      (phase),
        .busy       (busy)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every display strobe must match the next expected write
    always @(negedge clk) begin
        if (rst_n && disp_we) begin
            logic have;
            have = (exp_q.size() != 0);
            check("disp_expected", 32'(have), 32'd1);
            check("disp_addr", disp_addr, 32'h0040_0004);
            if (have) check("disp_data", disp_data, exp_q.pop_front());
        end
    end

    // Driver: one-cycle key pulse, accepted at the next rising edge
    task automatic press(input logic [7:0] k);
        @(posedge clk);
        #1;
        key_valid = 1'b1;
        key_code  = k;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    // Driver: wait (bounded) for alu_req, then return a result after `lat` cycles
    task automatic alu_respond(input int lat, input logic [31:0] res);
        int n;
        n = 0;
        while (!alu_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("alu_req_seen", 32'(alu_req), 32'd1);
        repeat (lat - 1) @(posedge clk);
        @(posedge clk);
        #1;
        alu_done   = 1'b1;
        alu_result = res;
        @(posedge clk);
        #1;
        alu_done   = 1'b0;
        alu_result = 32'h0;
    endtask

    initial begin
        key_valid  = 1'b0;
        key_code   = 8'h00;
        alu_done   = 1'b0;
        alu_result = 32'h0;
        rst_n      = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_alu_req", 32'(alu_req), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_a", alu_a, 32'h0);
        check("rst_alu_b", alu_b, 32'h0);
        check("rst_disp_we", 32'(disp_we), 32'd0);
        check("rst_disp_data", disp_data, 32'h0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 12 + 3 = with result 0x99
        exp_q.push_back(32'h31);
        exp_q.push_back(32'h3132);
        exp_q.push_back(32'h33);
        exp_q.push_back(32'h99);
        press(8'h31);
        check("t1_phase_opa", 32'(phase), 32'd1);
        press(8'h32);
        press(8'h2B);
        check("t1_phase_opb", 32'(phase), 32'd2);
        press(8'h33);
        press(8'h3D);
        check("t1_req", 32'(alu_req), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_phase_exec", 32'(phase), 32'd3);
        check("t1_a", alu_a, 32'h0000_3132);
        check("t1_b", alu_b, 32'h0000_0033);
        check("t1_op", 32'(alu_op), 32'd0);
        alu_respond(3, 32'h0000_0099);
        check("t1_req_fall", 32'(alu_req), 32'd0);
        check("t1_phase_show", 32'(phase), 32'd0);

        // Clear from SHOW, then 5 digits (5th dropped) plus an unknown key
        exp_q.push_back(32'h0);
        press(8'h43);
        exp_q.push_back(32'h31);
        exp_q.push_back(32'h3132);
        exp_q.push_back(32'h313233);
        exp_q.push_back(32'h31323334);
        press(8'h31);
        press(8'h32);
        press(8'h33);
        press(8'h34);
        press(8'h41);
        press(8'h35);
        check("t2_a_full", alu_a, 32'h3132_3334);
        check("t2_phase", 32'(phase), 32'd1);
        exp_q.push_back(32'h0);
        press(8'h43);
        check("t2_clr_a", alu_a, 32'h0);

        // Ignored keys: operator and '=' in IDLE, '=' with empty B, op replace
        press(8'h2B);
        check("t3_op_idle_phase", 32'(phase), 32'd0);
        press(8'h3D);
        check("t3_eq_idle_req", 32'(alu_req), 32'd0);
        exp_q.push_back(32'h35);
        press(8'h35);
        press(8'h2A);
        check("t3_op_mul", 32'(alu_op), 32'd2);
        press(8'h3D);
        check("t3_eq_emptyb_phase", 32'(phase), 32'd2);
        check("t3_eq_emptyb_req", 32'(alu_req), 32'd0);
        press(8'h2D);
        check("t3_op_replaced", 32'(alu_op), 32'd1);
        exp_q.push_back(32'h32);
        press(8'h32);
        press(8'h2B);
        check("t3_op_kept", 32'(alu_op), 32'd1);
        press(8'h3D);
        exp_q.push_back(32'h10);
        alu_respond(2, 32'h0000_0010);

        // Chaining from SHOW: result 0x10 - '2'
        press(8'h2D);
        check("t4_phase_opb", 32'(phase), 32'd2);
        exp_q.push_back(32'h32);
        press(8'h32);
        press(8'h3D);
        check("t4_a", alu_a, 32'h0000_0010);
        check("t4_op", 32'(alu_op), 32'd1);
        check("t4_b", alu_b, 32'h0000_0032);
        // 'C' in EXEC is dropped
        press(8'h43);
        check("t4_clr_exec_req", 32'(alu_req), 32'd1);
        check("t4_clr_exec_phase", 32'(phase), 32'd3);
        // Key and done in the same cycle: done wins, key dropped
        exp_q.push_back(32'h42);
        @(posedge clk);
        #1;
        key_valid  = 1'b1;
        key_code   = 8'h43;
        alu_done   = 1'b1;
        alu_result = 32'h42;
        @(posedge clk);
        #1;
        key_valid  = 1'b0;
        alu_done   = 1'b0;
        alu_result = 32'h0;
        check("t4_same_cycle_req", 32'(alu_req), 32'd0);
        check("t4_same_cycle_data", disp_data, 32'h42);
        @(posedge clk);
        #1;
        check("t4_same_cycle_show", 32'(disp_data), 32'h42);

        // SHOW + digit starts fresh
        exp_q.push_back(32'h39);
        press(8'h39);
        check("t5_show_digit_a", alu_a, 32'h39);
        check("t5_show_digit_phase", 32'(phase), 32'd1);

        // 'C' in OPB
        press(8'h2B);
        exp_q.push_back(32'h34);
        press(8'h34);
        exp_q.push_back(32'h0);
        press(8'h43);
        check("t6_clr_opb_phase", 32'(phase), 32'd0);
        check("t6_clr_opb_data", disp_data, 32'h0);
        check("t6_clr_opb_b", alu_b, 32'h0);

        // Asynchronous reset in EXEC
        exp_q.push_back(32'h36);
        press(8'h36);
        press(8'h2B);
        exp_q.push_back(32'h31);
        press(8'h31);
        press(8'h3D);
        check("t7_req_before", 32'(alu_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_async_req", 32'(alu_req), 32'd0);
        check("t7_async_phase", 32'(phase), 32'd0);
        check("t7_async_busy", 32'(busy), 32'd0);
        check("t7_async_a", alu_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(32'h37);
        press(8'h37);
        check("t7_after_a", alu_a, 32'h37);
        check("t7_after_phase", 32'(phase), 32'd1);

        repeat (3) @(posedge clk);
        #1;
        check("disp_pending", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
